// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch
// Description : Instruction-fetch responder for the DLX core. Accepts a fetch
//               address from the PC stage, runs a req/ack read on the
//               instruction-memory bus and returns the instruction with a
//               one-cycle valid pulse. Misaligned and timed-out fetches are
//               reported as faults.
//
// Parameters  : TIMEOUT   cycles to wait for mem_ack before faulting
//                         (0 = never time out, range 0..65535)
//
// Build macro : IFETCH_HIT_BUF_EN  one-entry {valid, address, data} buffer
//                                  that serves repeat fetches of the last
//                                  fault-free bus completion without a bus
//                                  access. Undefined: every aligned fetch
//                                  goes to the bus and inv is ignored.
//
// Ports       : clk          clock, rising edge
//               reset_n      synchronous active-low reset
//               i_req        fetch request strobe (ignored while busy)
//               i_address    byte address of the instruction
//               inv          invalidate the hit buffer
//               instr        last fetched instruction (held)
//               instr_valid  one-cycle pulse when instr/fault update
//               fault        00 ok, 01 misaligned, 10 bus timeout (held)
//               busy         bus transaction outstanding
//               mem_req      bus read request
//               mem_addr     bus read address, stable while mem_req
//               mem_ack      bus acknowledge, mem_rdata valid same cycle
//               mem_rdata    bus read data
//
// Revision    : 1.0  initial release
// ============================================================================
module ifetch #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_address,
    input  logic        inv,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [1:0]  fault,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] c_TIMEOUT   = 16'(TIMEOUT);

    localparam logic [0:0]  c_IDLE      = 1'b0;
    localparam logic [0:0]  c_WAIT      = 1'b1;

    localparam logic [1:0]  c_FAULT_OK  = 2'b00;
    localparam logic [1:0]  c_FAULT_MIS = 2'b01;
    localparam logic [1:0]  c_FAULT_TMO = 2'b10;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [15:0] r_count;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [1:0]  r_fault;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;

    logic [0:0]  w_state_nxt;
    logic [15:0] w_count_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_instr_valid_nxt;
    logic [1:0]  w_fault_nxt;
    logic        w_mem_req_nxt;
    logic [31:0] w_mem_addr_nxt;

    logic        w_misaligned;
    logic        w_hit;
    logic [31:0] w_hit_data;
    logic        w_fill;

    assign w_misaligned = (i_address[1:0] != 2'b00);

    // ------------------------------------------------------------------------
    // Optional one-entry hit buffer
    // ------------------------------------------------------------------------
`ifdef IFETCH_HIT_BUF_EN
    logic        r_hb_valid;
    logic [31:0] r_hb_addr;
    logic [31:0] r_hb_data;

    // An invalidate in the same cycle as a lookup suppresses the hit so a
    // stale entry is never returned after software asked for a flush.
    assign w_hit      = r_hb_valid && !inv && (r_hb_addr == i_address);
    assign w_hit_data = r_hb_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hb_valid <= 1'b0;
            r_hb_addr  <= 32'h0;
            r_hb_data  <= 32'h0;
        end else if (inv) begin
            // inv dominates a simultaneous fill: the entry stays invalid.
            r_hb_valid <= 1'b0;
        end else if (w_fill) begin
            r_hb_valid <= 1'b1;
            r_hb_addr  <= r_mem_addr;
            r_hb_data  <= mem_rdata;
        end
    end
`else
    logic w_unused_inv;
    logic w_unused_fill;

    assign w_hit         = 1'b0;
    assign w_hit_data    = 32'h0;
    assign w_unused_inv  = inv;
    assign w_unused_fill = w_fill;
`endif

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = 1'b0;
        w_fault_nxt       = r_fault;
        w_mem_req_nxt     = r_mem_req;
        w_mem_addr_nxt    = r_mem_addr;
        w_fill            = 1'b0;

        case (r_state)
            c_IDLE: begin
                // mem_ack in IDLE is deliberately ignored.
                if (i_req) begin
                    if (w_misaligned) begin
                        w_instr_nxt       = 32'h0;
                        w_fault_nxt       = c_FAULT_MIS;
                        w_instr_valid_nxt = 1'b1;
                    end else if (w_hit) begin
                        w_instr_nxt       = w_hit_data;
                        w_fault_nxt       = c_FAULT_OK;
                        w_instr_valid_nxt = 1'b1;
                    end else begin
                        w_mem_req_nxt  = 1'b1;
                        w_mem_addr_nxt = i_address;
                        w_count_nxt    = 16'h0;
                        w_state_nxt    = c_WAIT;
                    end
                end
            end

            c_WAIT: begin
                // Ack is tested first so it wins over a coincident timeout.
                // i_req is dropped here, never queued.
                if (mem_ack) begin
                    w_instr_nxt       = mem_rdata;
                    w_fault_nxt       = c_FAULT_OK;
                    w_instr_valid_nxt = 1'b1;
                    w_mem_req_nxt     = 1'b0;
                    w_state_nxt       = c_IDLE;
                    w_fill            = 1'b1;
                end else if (c_TIMEOUT != 16'h0) begin
                    // The compare-before-increment keeps the counter from
                    // ever passing TIMEOUT, so it cannot wrap.
                    if (r_count == c_TIMEOUT) begin
                        w_instr_nxt       = 32'h0;
                        w_fault_nxt       = c_FAULT_TMO;
                        w_instr_valid_nxt = 1'b1;
                        w_mem_req_nxt     = 1'b0;
                        w_state_nxt       = c_IDLE;
                    end else begin
                        w_count_nxt = r_count + 16'h1;
                    end
                end
            end

            default: begin
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_count       <= 16'h0;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_fault       <= c_FAULT_OK;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fault       = r_fault;
    assign busy        = (r_state == c_WAIT);
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch
// Description : Self-checking bench for ifetch (TIMEOUT = 4). Expected
//               completions are queued when a fetch is issued and compared
//               by a monitor whenever instr_valid pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_address;
    logic        inv;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  fault;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ifetch #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (i_req),
        .i_address   (i_address),
        .inv         (inv),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fault       (fault),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Scoreboard monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin : p_monitor
        exp_t e;
        if (instr_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: instr_valid=1 instr=%h fault=%b, required no completion",
                         instr, fault);
            end else begin
                e = sb.pop_front();
                if (instr !== e.instr || fault !== e.fault) begin
                    failures++;
                    $display("FAIL completion: instr=%h fault=%b, required instr=%h fault=%b",
                             instr, fault, e.instr, e.fault);
                end
            end
        end
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a complete bus fetch with an immediate ack; the monitor checks it.
    task automatic bus_fetch(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back({data, 2'b00});
        i_req     = 1'b1;
        i_address = addr;
        tick();
        i_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        i_req     = 1'b0;
        i_address = 32'h0;
        inv       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        checks++;
        if (instr !== 32'h0 || fault !== 2'b00 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: instr=%h fault=%b valid=%b, required 0/00/0",
                     instr, fault, instr_valid);
        end
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: busy=%b mem_req=%b mem_addr=%h, required 0/0/0",
                     busy, mem_req, mem_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_aligned;
        sb.push_back({32'h20010005, 2'b00});
        i_req     = 1'b1;
        i_address = 32'h100;
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL aligned_req: mem_req=%b busy=%b mem_addr=%h, required 1/1/00000100",
                     mem_req, busy, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h20010005;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL aligned_done: valid=%b mem_req=%b busy=%b, required 1/0/0",
                     instr_valid, mem_req, busy);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h20010005) begin
            failures++;
            $display("FAIL aligned_hold: valid=%b instr=%h, required 0/20010005",
                     instr_valid, instr);
        end
    endtask

    task automatic test_misaligned;
        sb.push_back({32'h0, 2'b01});
        i_req     = 1'b1;
        i_address = 32'h102;
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b1 || fault !== 2'b01) begin
            failures++;
            $display("FAIL misaligned: mem_req=%b busy=%b valid=%b fault=%b, required 0/0/1/01",
                     mem_req, busy, instr_valid, fault);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_after: valid=%b mem_req=%b, required 0/0",
                     instr_valid, mem_req);
        end
    endtask

    task automatic test_timeout;
        int  n_req;
        bit  done;
        n_req = 0;
        done  = 1'b0;
        sb.push_back({32'h0, 2'b10});
        i_req     = 1'b1;
        i_address = 32'h200;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            i_req = 1'b0;
            if (mem_req === 1'b1) n_req++;
            if (instr_valid === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || n_req != 5) begin
            failures++;
            $display("FAIL timeout_len: completed=%0d mem_req_cycles=%0d, required 1/5",
                     done, n_req);
        end
        checks++;
        if (fault !== 2'b10 || instr !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_status: fault=%b instr=%h busy=%b, required 10/0/0",
                     fault, instr, busy);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || fault !== 2'b10 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: valid=%b instr=%h fault=%b mem_req=%b, required 0/0/10/0",
                     instr_valid, instr, fault, mem_req);
        end
    endtask

    task automatic test_ack_timeout_coincide;
        sb.push_back({32'hDEADBEEF, 2'b00});
        i_req     = 1'b1;
        i_address = 32'h204;
        tick();
        i_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL coincide_wait%0d: mem_req=%b valid=%b, required 1/0",
                         k, mem_req, instr_valid);
            end
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || fault !== 2'b00 || instr !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL coincide_done: valid=%b fault=%b instr=%h, required 1/00/deadbeef",
                     instr_valid, fault, instr);
        end
        tick();
    endtask

    task automatic test_wait_req_dropped;
        sb.push_back({32'hAAAA0001, 2'b00});
        i_req     = 1'b1;
        i_address = 32'h600;
        tick();
        i_address = 32'h700;
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_addr !== 32'h600 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_drop_addr: mem_addr=%h busy=%b, required 00000600/1",
                     mem_addr, busy);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA0001;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || instr !== 32'hAAAA0001) begin
            failures++;
            $display("FAIL wait_drop_after: mem_req=%b busy=%b instr=%h, required 0/0/aaaa0001",
                     mem_req, busy, instr);
        end
    endtask

    task automatic test_back_to_back;
        sb.push_back({32'h0BAD0001, 2'b00});
        sb.push_back({32'h0BAD0002, 2'b00});
        i_req     = 1'b1;
        i_address = 32'h500;
        tick();
        i_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD0001;
        tick();
        mem_ack   = 1'b0;
        i_req     = 1'b1;
        i_address = 32'h504;
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h504 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: mem_req=%b mem_addr=%h valid=%b, required 1/00000504/0",
                     mem_req, mem_addr, instr_valid);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD0002;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait;
        i_req     = 1'b1;
        i_address = 32'h400;
        tick();
        i_req   = 1'b0;
        reset_n = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_abort: mem_req=%b busy=%b, required 0/0", mem_req, busy);
        end
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || fault !== 2'b00 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_wait_outputs: valid=%b instr=%h fault=%b mem_addr=%h, required 0/0/00/0",
                     instr_valid, instr, fault, mem_addr);
        end
        tick();
    endtask

    task automatic test_hit_buffer;
        bus_fetch(32'h300, 32'h12345678);
`ifdef IFETCH_HIT_BUF_EN
        sb.push_back({32'h12345678, 2'b00});
        i_req     = 1'b1;
        i_address = 32'h300;
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'h12345678) begin
            failures++;
            $display("FAIL hit: mem_req=%b busy=%b valid=%b instr=%h, required 0/0/1/12345678",
                     mem_req, busy, instr_valid, instr);
        end
        tick();
        inv = 1'b1;
        tick();
        inv = 1'b0;
`endif
        sb.push_back({32'hCAFEF00D, 2'b00});
        i_req     = 1'b1;
        i_address = 32'h300;
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL refetch_bus: mem_req=%b mem_addr=%h, required 1/00000300",
                     mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_timeout();
        test_ack_timeout_coincide();
        test_wait_req_dropped();
        test_back_to_back();
        test_reset_mid_wait();
        test_hit_buffer();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_completions: outstanding=%0d, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
